readwrite_register_bank: RTL and testbench
==========================================

READWRITE_REGISTER_BANK -- requirements
Module: readwrite_register_bank

Interface
REQ-001 SHALL have parameter ADDR_START, default 0: byte address of word 0; must be 4-byte aligned.
REQ-002 SHALL have parameter WORD_COUNT, default 4: number of WORD_W registers, range 1..256.
REQ-003 SHALL have parameter RO_MASK, default 0: WORD_W*WORD_COUNT bits; 1 = bit is hardware-owned and read-only to software.
REQ-004 SHALL have parameter W1C_MASK, default 0: WORD_W*WORD_COUNT bits; 1 = sticky status bit, set by hardware, cleared by software writing 1; RO_MASK wins where both are set.
REQ-005 SHALL have ports clk in 1 (rising edge) and aresetn in 1; one clock, reset asynchronous and active-low.
REQ-006 SHALL have i_req_addr in ADDR_W, i_req_wr_data in WORD_W, i_req_wr_en in 1, i_req_count in MEM_COUNT_W (NONE/BYTE/HALF/WORD).
REQ-007 SHALL have o_res_rd_data out WORD_W and o_res_code out MEM_CODE_W, both registered.
REQ-008 SHALL have i_hw_val in WORD_W*WORD_COUNT (source for RO bits) and i_hw_set in WORD_W*WORD_COUNT (set pulses for W1C bits).
REQ-009 SHALL have o_exposed_mem out WORD_W*WORD_COUNT (word j at bits [WORD_W*(j+1)-1 : WORD_W*j]), o_wr_strobe out WORD_COUNT, o_irq out 1.

Function
REQ-010 Every request SHALL produce its response exactly 1 cycle later; requests accepted every cycle, no back-pressure.
REQ-011 Priority order SHALL be: count NONE -> code INVALID, data 0; misaligned (HALF with addr[0]=1, WORD with addr[1:0]!=0) -> MISALIGNED; out of range -> OUT_OF_BOUNDS; else READ or WRITE.
REQ-012 Out of range SHALL mean addr < ADDR_START or (addr - ADDR_START)>>2 >= WORD_COUNT; index computed relative to ADDR_START.
REQ-013 Unknown count encodings SHALL return INVALID with no state change.
REQ-014 Reads SHALL right-justify the selected byte/half into o_res_rd_data, upper bits zero; WORD returns full word; non-READ codes return data 0.
REQ-015 Plain RW bits SHALL take write data only in addressed byte lanes; other lanes unchanged.
REQ-016 RO bits SHALL load i_hw_val every cycle; software writes to them ignored, code still WRITE.
REQ-017 W1C bits: next = (cur & ~clr) | set, where clr = write data 1 in addressed lanes; simultaneous set and clear SHALL leave bit 1.
REQ-018 o_wr_strobe[j] SHALL pulse 1 cycle, concurrent with the WRITE response, for each accepted write to word j; no pulse on errors.
REQ-019 o_exposed_mem SHALL reflect register contents directly (no extra delay).
REQ-020 A read in the cycle after a write to the same word SHALL return the written value.

Reset
REQ-021 On aresetn low, all registers, o_res_rd_data, o_res_code, o_wr_strobe and o_irq SHALL go to 0 immediately, regardless of clk.
REQ-022 A request presented in the cycle reset deasserts SHALL be processed normally; a request in flight when reset asserts SHALL be discarded.

Configuration
REQ-023 Macro REGBANK_IRQ_EN SHALL compile in interrupt logic: o_irq registered, asserted the cycle after any W1C bit is 1, deasserted the cycle after all W1C bits are 0.
REQ-024 Without REGBANK_IRQ_EN, o_irq SHALL remain port-present and tied to 0 with no interrupt logic synthesised.

Verification
REQ-025 ADDR_START=0x100, WORD_COUNT=4: WORD write 0xDEADBEEF @0x104, then WORD read @0x104 -> WRITE, strobe=0010, then READ 0xDEADBEEF.
REQ-026 BYTE write 0xAA @0x106, BYTE read @0x106 -> READ 0x000000AA; WORD read @0x104 -> 0xDEAABEEF.
REQ-027 HALF read @0x101 -> MISALIGNED; WORD read @0x110 -> OUT_OF_BOUNDS; WORD read @0x0FC -> OUT_OF_BOUNDS; count NONE -> INVALID, data 0.
REQ-028 W1C_MASK word 0 = 0x0000000F: pulse i_hw_set bit 2 -> read @0x100 = 0x4; write 0x4 with i_hw_set bit 2 high same cycle -> still 0x4; write 0x4 alone -> 0x0.
REQ-029 RO_MASK word 3 = 0xFFFFFFFF, i_hw_val word 3 = 0x12345678: write 0 @0x10C -> WRITE, read -> 0x12345678.
REQ-030 With REGBANK_IRQ_EN: set W1C bit -> o_irq high next cycle; clear it -> low next cycle; assert aresetn low mid-test -> o_irq and all registers 0 immediately.

Source files
------------

// File: rtl/readwrite_register_bank.sv
// readwrite_register_bank: byte-addressed bank of 32-bit RW/RO/W1C registers with a 1-cycle response.
// Count: 0 NONE, 1 BYTE, 2 HALF, 3 WORD (4..7 invalid). Code: 0 INVALID, 1 READ, 2 WRITE, 3 MISALIGNED, 4 OUT_OF_BOUNDS. Define REGBANK_IRQ_EN for o_irq.
module readwrite_register_bank #(
   parameter int ADDR_W = 32,
   parameter int ADDR_START = 0,
   parameter int WORD_COUNT = 4,
   localparam int WORD_W = 32,
   localparam int MEM_COUNT_W = 3,
   localparam int MEM_CODE_W = 3,
   parameter logic [WORD_W*WORD_COUNT-1:0] RO_MASK = '0,
   parameter logic [WORD_W*WORD_COUNT-1:0] W1C_MASK = '0
) (
   input  logic                         clk,
   input  logic                         aresetn,
   input  logic [ADDR_W-1:0]            i_req_addr,
   input  logic [WORD_W-1:0]            i_req_wr_data,
   input  logic                         i_req_wr_en,
   input  logic [MEM_COUNT_W-1:0]       i_req_count,
   output logic [WORD_W-1:0]            o_res_rd_data,
   output logic [MEM_CODE_W-1:0]        o_res_code,
   input  logic [WORD_W*WORD_COUNT-1:0] i_hw_val,
   input  logic [WORD_W*WORD_COUNT-1:0] i_hw_set,
   output logic [WORD_W*WORD_COUNT-1:0] o_exposed_mem,
   output logic [WORD_COUNT-1:0]        o_wr_strobe,
   output logic                         o_irq
);
   localparam int N = WORD_W * WORD_COUNT;
   localparam int IW = WORD_COUNT > 1 ? $clog2(WORD_COUNT) : 1;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ADDR_START);
   localparam logic [ADDR_W-1:0] WC = ADDR_W'(WORD_COUNT);
   localparam logic [MEM_COUNT_W-1:0] CNT_NONE = 0, CNT_BYTE = 1, CNT_HALF = 2, CNT_WORD = 3;
   localparam logic [MEM_CODE_W-1:0] CODE_INVALID = 0, CODE_READ = 1, CODE_WRITE = 2, CODE_MISALIGNED = 3, CODE_OOB = 4;
   localparam logic [N-1:0] W1C = W1C_MASK & ~RO_MASK;
   localparam logic [N-1:0] RW = ~(RO_MASK | W1C_MASK);

   logic [N-1:0] mem, nxt, wbits, wdata;
   logic [ADDR_W-1:0] off;
   logic [IW-1:0] idx;
   logic [3:0] lanes;
   logic [WORD_W-1:0] bm, rd_word, rd_val;
   logic [MEM_CODE_W-1:0] code;
   logic [WORD_COUNT-1:0] sel;

   always_comb begin
      off = i_req_addr - BASE;
      idx = off[IW+1:2];
      lanes = (i_req_count == CNT_BYTE ? 4'b0001 : i_req_count == CNT_HALF ? 4'b0011 : 4'b1111) << i_req_addr[1:0];
      for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{lanes[b]}};
      code = (i_req_count == CNT_NONE || i_req_count > CNT_WORD) ? CODE_INVALID
           : ((i_req_count == CNT_HALF && i_req_addr[0]) || (i_req_count == CNT_WORD && i_req_addr[1:0] != 2'b00)) ? CODE_MISALIGNED
           : (i_req_addr < BASE || (off >> 2) >= WC) ? CODE_OOB
           : i_req_wr_en ? CODE_WRITE : CODE_READ;
      rd_word = '0;
      sel = '0;
      wbits = '0;
      for (int j = 0; j < WORD_COUNT; j++) begin
         sel[j] = code == CODE_WRITE && idx == IW'(j);
         if (idx == IW'(j)) rd_word = mem[WORD_W*j +: WORD_W];
         wbits[WORD_W*j +: WORD_W] = sel[j] ? bm : '0;
      end
      rd_val = (rd_word >> {i_req_addr[1:0], 3'b000}) &
               (i_req_count == CNT_BYTE ? 32'h0000_00FF : i_req_count == CNT_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF);
      wdata = {WORD_COUNT{i_req_wr_data << {i_req_addr[1:0], 3'b000}}};
      // W1C: write-one clears only in addressed lanes, while a same-cycle hardware set still wins
      nxt = (RO_MASK & i_hw_val)
          | (W1C & ((mem & ~(wbits & wdata)) | i_hw_set))
          | (RW & ((mem & ~wbits) | (wdata & wbits)));
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         mem <= '0;
         o_res_rd_data <= '0;
         o_res_code <= '0;
         o_wr_strobe <= '0;
      end else begin
         mem <= nxt;
         o_res_rd_data <= code == CODE_READ ? rd_val : '0;
         o_res_code <= code;
         o_wr_strobe <= sel;
      end
   end

   assign o_exposed_mem = mem;

`ifdef REGBANK_IRQ_EN
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) o_irq <= 1'b0;
      else o_irq <= |(mem & W1C);
   end
`else
   assign o_irq = 1'b0;
`endif
endmodule

// File: tb/tb_readwrite_register_bank.sv
// tb_readwrite_register_bank: directed and random requests checked against a byte/bit-level model.
module tb_readwrite_register_bank;
   localparam logic [127:0] RO = {32'hFFFF_FFFF, 96'h0};
   localparam logic [127:0] W1C = 128'hF;
   localparam logic [2:0] INV = 0, RD = 1, WR = 2, MIS = 3, OOB = 4;

   logic clk = 0, aresetn = 0;
   logic [31:0] addr = 0, wr_data = 0;
   logic wr_en = 0;
   logic [2:0] count = 0;
   logic [127:0] hw_val = 0, hw_set = 0;
   logic [31:0] rd_data;
   logic [2:0] res_code;
   logic [127:0] exposed;
   logic [3:0] strobe;
   logic irq;
   int errs = 0, checks = 0;
   logic [31:0] m[4];
   logic [31:0] last_rd;

   always #5 clk = ~clk;

   readwrite_register_bank #(
      .ADDR_W(32), .ADDR_START(32'h100), .WORD_COUNT(4), .RO_MASK(RO), .W1C_MASK(W1C)
   ) dut (
      .clk(clk), .aresetn(aresetn), .i_req_addr(addr), .i_req_wr_data(wr_data),
      .i_req_wr_en(wr_en), .i_req_count(count), .o_res_rd_data(rd_data), .o_res_code(res_code),
      .i_hw_val(hw_val), .i_hw_set(hw_set), .o_exposed_mem(exposed), .o_wr_strobe(strobe), .o_irq(irq)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one request in the low clock phase, checks the response after the next rising edge.
   task automatic req(input logic [2:0] cnt, input logic [31:0] a, input bit wr, input logic [31:0] d);
      logic [2:0] ec;
      logic [31:0] erd;
      logic [31:0] nm[4];
      logic [3:0] es;
      logic eirq;
      int sz, w, lo, p;
      count = cnt; addr = a; wr_en = wr; wr_data = d;
      sz = cnt == 1 ? 1 : cnt == 2 ? 2 : cnt == 3 ? 4 : 0;
      if (sz == 0) ec = INV;
      else if ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 0)) ec = MIS;
      else if (a < 32'h100 || ((a - 32'h100) >> 2) >= 4) ec = OOB;
      else ec = wr ? WR : RD;
      w = (ec == RD || ec == WR) ? int'((a - 32'h100) >> 2) : 0;
      lo = int'(a[1:0]);
      erd = 0; es = 0; nm = m;
      eirq = |(W1C & ~RO & {m[3], m[2], m[1], m[0]});
`ifndef REGBANK_IRQ_EN
      eirq = 0;
`endif
      if (ec == RD)
         for (int k = 0; k < sz; k++) erd[8*k +: 8] = m[w][8*(lo+k) +: 8];
      if (ec == WR) begin
         es[w] = 1;
         for (int k = 0; k < sz; k++)
            for (int b = 0; b < 8; b++) begin
               p = 8*(lo+k) + b;
               if (RO[32*w+p]) ;
               else if (W1C[32*w+p]) begin if (d[8*k+b]) nm[w][p] = 0; end
               else nm[w][p] = d[8*k+b];
            end
      end
      for (int ww = 0; ww < 4; ww++)
         for (int b = 0; b < 32; b++) begin
            if (RO[32*ww+b]) nm[ww][b] = hw_val[32*ww+b];
            else if (W1C[32*ww+b] && hw_set[32*ww+b]) nm[ww][b] = 1;
         end
      @(posedge clk);
      #1;
      check("code", res_code, ec);
      check("rd_data", rd_data, erd);
      check("strobe", strobe, es);
      check("mem", exposed, {nm[3], nm[2], nm[1], nm[0]});
      check("irq", irq, eirq);
      m = nm;
      last_rd = rd_data;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m[i] = 0;
      hw_val = {32'h1234_5678, {3{32'hFFFF_FFFF}}};
      #2;
      check("rst_code", res_code, 0);
      check("rst_rd", rd_data, 0);
      check("rst_strobe", strobe, 0);
      check("rst_mem", exposed, 0);
      check("rst_irq", irq, 0);
      @(negedge clk); @(negedge clk);
      aresetn = 1;
      req(3, 32'h104, 1, 32'hDEAD_BEEF);
      check("w_strobe", strobe, 4'b0010);
      req(3, 32'h104, 0, 0);
      check("w_rd", last_rd, 32'hDEAD_BEEF);
      req(1, 32'h106, 1, 32'hAA);
      req(1, 32'h106, 0, 0);
      check("b_rd", last_rd, 32'hAA);
      req(3, 32'h104, 0, 0);
      check("b_word", last_rd, 32'hDEAA_BEEF);
      req(2, 32'h101, 0, 0);
      check("mis_code", res_code, MIS);
      req(3, 32'h110, 0, 0);
      check("oob_hi", res_code, OOB);
      req(3, 32'h0FC, 0, 0);
      check("oob_lo", res_code, OOB);
      req(0, 32'h104, 0, 0);
      check("none_code", res_code, INV);
      req(6, 32'h104, 1, 32'hFFFF_FFFF);
      hw_set = 128'h4;
      req(0, 0, 0, 0);
      hw_set = 0;
      req(3, 32'h100, 0, 0);
      check("w1c_set", last_rd, 32'h4);
      hw_set = 128'h4;
      req(3, 32'h100, 1, 32'h4);
      hw_set = 0;
      req(3, 32'h100, 0, 0);
      check("w1c_both", last_rd, 32'h4);
      req(3, 32'h100, 1, 32'h4);
      req(3, 32'h100, 0, 0);
      check("w1c_clr", last_rd, 32'h0);
      req(3, 32'h10C, 1, 0);
      check("ro_code", res_code, WR);
      req(3, 32'h10C, 0, 0);
      check("ro_rd", last_rd, 32'h1234_5678);
      hw_set = 128'h8;
      req(0, 0, 0, 0);
      hw_set = 0;
      req(0, 0, 0, 0);
      #3 aresetn = 0;
      #1;
      check("arst_code", res_code, 0);
      check("arst_rd", rd_data, 0);
      check("arst_strobe", strobe, 0);
      check("arst_mem", exposed, 0);
      check("arst_irq", irq, 0);
      for (int i = 0; i < 4; i++) m[i] = 0;
      @(negedge clk); @(negedge clk);
      aresetn = 1;
      req(3, 32'h100, 0, 0);
      for (int i = 0; i < 300; i++) begin
         hw_val = {$urandom, $urandom, $urandom, $urandom};
         hw_set = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom, $urandom, $urandom} : 128'h0;
         req(($urandom_range(0, 7) < 6) ? 3'($urandom_range(1, 3)) : 3'($urandom_range(0, 7)),
             32'h0F8 + 32'($urandom_range(0, 31)), bit'($urandom_range(0, 1)), $urandom);
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
